// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a single-port data memory.
// One memory access per grant; ack and read data are returned registered to the winner.
module dmem_arb_port #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          gnt,
  input  logic          we,
  input  logic [DW-1:0] mem_rdata,
  output logic          ack,
  output logic [DW-1:0] rdata
);
  // rdata holds its last read value across write accesses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack   <= 1'b0;
      rdata <= '0;
    end else begin
      ack <= gnt;
      if (gnt && !we) rdata <= mem_rdata;
    end
  end
endmodule

module dmem_arbiter #(
  parameter int AW = 16,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ack,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ack,
  output logic [DW-1:0] b_rdata,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);
  localparam int NP = 2;

  typedef enum logic [1:0] {IDLE, GNT_A, GNT_B, ACK} state_t;

  state_t state, state_nxt;
  logic   last_b, last_b_nxt;

  logic [NP-1:0]         gnt, we, ack;
  logic [NP-1:0][DW-1:0] rdata;

  assign we  = {b_we, a_we};
  assign gnt = {state == GNT_B, state == GNT_A};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      last_b <= 1'b1;
    end else begin
      state  <= state_nxt;
      last_b <= last_b_nxt;
    end
  end

  // In ACK the just-served port is masked: its requester still holds req this cycle
  always_comb begin
    state_nxt  = state;
    last_b_nxt = last_b;
    unique case (state)
      IDLE: begin
        if (a_req && (!b_req || last_b)) state_nxt = GNT_A;
        else if (b_req)                  state_nxt = GNT_B;
      end
      GNT_A: begin
        state_nxt  = ACK;
        last_b_nxt = 1'b0;
      end
      GNT_B: begin
        state_nxt  = ACK;
        last_b_nxt = 1'b1;
      end
      ACK: begin
        if (last_b && a_req)       state_nxt = GNT_A;
        else if (!last_b && b_req) state_nxt = GNT_B;
        else                       state_nxt = IDLE;
      end
    endcase
  end

  for (genvar p = 0; p < NP; p++) begin : g_port
    dmem_arb_port #(.DW(DW)) u_port (
      .clk       (clk),
      .rst       (rst),
      .gnt       (gnt[p]),
      .we        (we[p]),
      .mem_rdata (mem_rdata),
      .ack       (ack[p]),
      .rdata     (rdata[p])
    );
  end

  assign a_ack   = ack[0];
  assign b_ack   = ack[1];
  assign a_rdata = rdata[0];
  assign b_rdata = rdata[1];

  // Strobe comes from the state register so a grant issues exactly one write
  assign mem_wr    = |(gnt & we);
  assign mem_addr  = gnt[1] ? b_addr  : a_addr;
  assign mem_wdata = gnt[1] ? b_wdata : a_wdata;
  assign busy      = (state != IDLE);
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed latency/priority/reset cases, then random traffic
// checked against a transaction-level scoreboard and reference memory.
module tb_dmem_arbiter;
  localparam int AW = 16;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr, mem_addr;
  logic [DW-1:0] a_wdata, b_wdata, a_rdata, b_rdata, mem_wdata, mem_rdata;
  logic          a_ack, b_ack, mem_wr, busy;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  function automatic logic [DW-1:0] init_val(input int unsigned i);
    logic [15:0] lo;
    lo = i[15:0];
    return {~lo, lo} ^ 32'h5A5A_0000;
  endfunction

  // Memory the arbiter drives: combinational read, clocked write
  logic [DW-1:0] mem [0:65535];
  bit            mem_init_done;
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 65536; i++) mem[i] <= init_val(i);
      mem_init_done <= 1'b1;
    end else if (mem_wr) begin
      mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr];

  logic [DW-1:0] ref_mem [0:65535];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  function automatic logic [AW-1:0] pick_addr();
    int unsigned r;
    r = $urandom_range(0, 7);
    if (r == 0) return 16'h0000;
    if (r == 1) return 16'hFFFF;
    return 16'h0080 + 16'(r);
  endfunction

  int            cyc, ra, rb, last_ack_cyc, wr_pulses, wr_acked;
  bit            a_done, b_done, have_ack, last_ack_b, other_req;
  logic [DW-1:0] exp_ard, exp_brd, prev_wdata;
  logic [AW-1:0] prev_addr;
  logic          prev_wr;

  initial begin
    for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(i);

    // Reset held with both ports requesting
    rst = 1'b1;
    a_req = 1'b1; a_we = 1'b0; a_addr = 16'h0100; a_wdata = '0;
    b_req = 1'b1; b_we = 1'b0; b_addr = 16'h0200; b_wdata = '0;
    repeat (3) tick();
    smp();
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_a_ack", a_ack, 0);
    chk("rst_b_ack", b_ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_a_rdata", a_rdata, 0);
    chk("rst_b_rdata", b_rdata, 0);
    tick(); rst = 1'b0;
    smp(); chk("rel_c0_busy", busy, 0);
    tick(); smp();
    chk("rel_c1_addr", mem_addr, 16'h0100);
    chk("rel_c1_busy", busy, 1);
    chk("rel_c1_a_ack", a_ack, 0);
    tick(); smp();
    chk("rel_c2_a_ack", a_ack, 1);
    chk("rel_c2_b_ack", b_ack, 0);
    chk("rel_c2_a_rdata", a_rdata, ref_mem[16'h0100]);
    tick(); a_req = 1'b0;
    smp(); chk("rel_c3_addr", mem_addr, 16'h0200);
    tick(); smp();
    chk("rel_c4_b_ack", b_ack, 1);
    chk("rel_c4_b_rdata", b_rdata, ref_mem[16'h0200]);
    tick(); b_req = 1'b0;
    smp(); chk("rel_idle_busy", busy, 0);

    // Port A write then read back
    tick(); a_req = 1'b1; a_we = 1'b1; a_addr = 16'h0010; a_wdata = 32'hDEADBEEF;
    tick(); smp();
    chk("wr_mem_wr", mem_wr, 1);
    chk("wr_addr", mem_addr, 16'h0010);
    chk("wr_wdata", mem_wdata, 32'hDEADBEEF);
    chk("wr_ack_early", a_ack, 0);
    tick(); smp();
    chk("wr_a_ack", a_ack, 1);
    chk("wr_single_strobe", mem_wr, 0);
    chk("wr_rdata_hold", a_rdata, ref_mem[16'h0100]);
    ref_mem[16'h0010] = 32'hDEADBEEF;
    tick(); a_req = 1'b0;
    smp(); chk("wr_ack_clear", a_ack, 0);
    tick(); a_req = 1'b1; a_we = 1'b0;
    tick(); tick(); smp();
    chk("rd_a_ack", a_ack, 1);
    chk("rd_a_rdata", a_rdata, 32'hDEADBEEF);
    tick(); a_req = 1'b0;

    // Contention: A served last, so B leads and grants alternate every 2 cycles
    tick(); a_req = 1'b1; a_addr = 16'h0030; b_req = 1'b1; b_addr = 16'h0040;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 9) a_req = 1'b0;
      smp();
      chk($sformatf("cont_a_ack%0d", c), a_ack, (c % 4 == 0));
      chk($sformatf("cont_b_ack%0d", c), b_ack, (c % 4 == 2));
      if (c == 8)  chk("cont_a_rdata", a_rdata, ref_mem[16'h0030]);
      if (c == 10) chk("cont_b_rdata", b_rdata, ref_mem[16'h0040]);
    end
    tick(); b_req = 1'b0;
    smp(); chk("cont_idle", busy, 0);

    // B-only stream: 3-cycle cadence, busy low in the IDLE slot
    tick(); b_req = 1'b1; b_addr = 16'h0020;
    smp(); chk("bstr_c0_busy", busy, 0);
    for (int c = 1; c <= 8; c++) begin
      tick(); smp();
      chk($sformatf("bstr_busy%0d", c), busy, (c % 3 != 0));
      chk($sformatf("bstr_ack%0d", c), b_ack, (c % 3 == 2));
    end
    chk("bstr_rdata", b_rdata, ref_mem[16'h0020]);
    tick(); b_req = 1'b0;
    smp(); chk("bstr_end_busy", busy, 0);

    // Read-after-write across ports at the top address
    tick(); b_req = 1'b1; b_we = 1'b1; b_addr = 16'hFFFF; b_wdata = 32'h12345678;
    tick(); a_req = 1'b1; a_we = 1'b0; a_addr = 16'hFFFF;
    smp(); chk("raw_b_wr", mem_wr, 1);
    tick(); smp();
    chk("raw_b_ack", b_ack, 1);
    ref_mem[16'hFFFF] = 32'h12345678;
    tick(); b_req = 1'b0; b_we = 1'b0;
    smp();
    chk("raw_a_addr", mem_addr, 16'hFFFF);
    chk("raw_a_nowr", mem_wr, 0);
    tick(); smp();
    chk("raw_a_ack", a_ack, 1);
    chk("raw_a_rdata", a_rdata, 32'h12345678);
    tick(); a_req = 1'b0;

    // Async reset landing in a GNT_B write cycle
    tick(); b_req = 1'b1; b_we = 1'b1; b_addr = 16'h0050; b_wdata = 32'hCAFEF00D;
    tick(); smp();
    chk("rg_wr_pre", mem_wr, 1);
    #1 rst = 1'b1;
    #1;
    chk("rg_wr_drop", mem_wr, 0);
    chk("rg_busy", busy, 0);
    chk("rg_b_ack", b_ack, 0);
    tick(); b_req = 1'b0; b_we = 1'b0;
    tick(); rst = 1'b0;
    smp();
    chk("rg_b_ack_after", b_ack, 0);
    chk("rg_idle", busy, 0);
    chk("rg_nowrite", mem[16'h0050], ref_mem[16'h0050]);
    chk("rg_a_rdata", a_rdata, 0);
    tick(); a_req = 1'b1; a_addr = 16'h0060; b_req = 1'b1; b_addr = 16'h0070;
    tick(); smp(); chk("rs_first_addr", mem_addr, 16'h0060);
    tick(); smp();
    chk("rs_a_ack", a_ack, 1);
    chk("rs_b_ack", b_ack, 0);
    tick(); a_req = 1'b0;
    tick(); smp(); chk("rs_b_second", b_ack, 1);
    tick(); b_req = 1'b0;
    smp();
    exp_ard = ref_mem[16'h0060];
    exp_brd = ref_mem[16'h0070];
    prev_wr = mem_wr; prev_addr = mem_addr; prev_wdata = mem_wdata;

    // Random traffic against the scoreboard
    cyc = 0; wr_pulses = 0; wr_acked = 0;
    a_done = 0; b_done = 0; have_ack = 0;
    for (int k = 0; k < 3000; k++) begin
      tick(); cyc++;
      if (a_done) a_req = 1'b0;
      if (b_done) b_req = 1'b0;
      a_done = 0; b_done = 0;
      if (!a_req && k < 2990 && $urandom_range(0, 1) == 1) begin
        a_req = 1'b1; a_we = 1'($urandom_range(0, 1)); a_addr = pick_addr(); a_wdata = $urandom; ra = cyc;
      end
      if (!b_req && k < 2990 && $urandom_range(0, 1) == 1) begin
        b_req = 1'b1; b_we = 1'($urandom_range(0, 1)); b_addr = pick_addr(); b_wdata = $urandom; rb = cyc;
      end
      smp();
      chk("rnd_excl", a_ack & b_ack, 0);
      if (mem_wr) wr_pulses++;
      if (a_ack) begin
        chk("rnd_a_req", a_req, 1);
        chk("rnd_a_lat", (cyc - ra >= 2) && (cyc - ra <= 4), 1);
        chk("rnd_a_bus_wr", prev_wr, a_we);
        chk("rnd_a_bus_addr", prev_addr, a_addr);
        if (a_we) begin
          chk("rnd_a_bus_wdata", prev_wdata, a_wdata);
          ref_mem[a_addr] = a_wdata;
          wr_acked++;
        end else begin
          exp_ard = ref_mem[a_addr];
        end
        chk("rnd_a_rdata", a_rdata, exp_ard);
        if (have_ack) begin
          if (other_req) begin
            chk("rnd_a_alt", last_ack_b, 1);
            chk("rnd_a_gap2", cyc - last_ack_cyc, 2);
          end else begin
            chk("rnd_a_gap3", cyc - last_ack_cyc >= 3, 1);
          end
        end
        have_ack = 1; last_ack_cyc = cyc; last_ack_b = 0; other_req = b_req; a_done = 1;
      end
      if (b_ack) begin
        chk("rnd_b_req", b_req, 1);
        chk("rnd_b_lat", (cyc - rb >= 2) && (cyc - rb <= 4), 1);
        chk("rnd_b_bus_wr", prev_wr, b_we);
        chk("rnd_b_bus_addr", prev_addr, b_addr);
        if (b_we) begin
          chk("rnd_b_bus_wdata", prev_wdata, b_wdata);
          ref_mem[b_addr] = b_wdata;
          wr_acked++;
        end else begin
          exp_brd = ref_mem[b_addr];
        end
        chk("rnd_b_rdata", b_rdata, exp_brd);
        if (have_ack) begin
          if (other_req) begin
            chk("rnd_b_alt", last_ack_b, 0);
            chk("rnd_b_gap2", cyc - last_ack_cyc, 2);
          end else begin
            chk("rnd_b_gap3", cyc - last_ack_cyc >= 3, 1);
          end
        end
        have_ack = 1; last_ack_cyc = cyc; last_ack_b = 1; other_req = a_req; b_done = 1;
      end
      prev_wr = mem_wr; prev_addr = mem_addr; prev_wdata = mem_wdata;
    end
    if (a_done) a_req = 1'b0;
    if (b_done) b_req = 1'b0;
    chk("rnd_drained", {a_req, b_req}, 0);
    chk("rnd_wr_count", wr_pulses, wr_acked);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-port data memory (combinational read, clocked write).
- Port A serves the pipeline MEM stage; port B serves the debug/loader master.
- Round-robin on contention, one memory access per grant, registered ack and read data back to the winning requester.
- Drives the memory's wr/addr/datain directly and samples its dataout.

Parameters:
AW, 16, memory word-address width
DW, 32, data word width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
a_req  in  1  port A request; held until a_ack
a_we  in  1  port A write enable (1=write, 0=read); stable while a_req
a_addr  in  AW  port A word address; stable while a_req
a_wdata  in  DW  port A write data; stable while a_req
a_ack  out  1  port A one-cycle completion pulse, registered
a_rdata  out  DW  port A read data, valid when a_ack=1
b_req, b_we, b_addr, b_wdata, b_ack, b_rdata  -- same widths and meanings as port A, for port B
mem_wr  out  1  memory write strobe
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory combinational read data
busy  out  1  1 whenever state != IDLE

Behaviour:
- State register: IDLE, GNT_A, GNT_B, ACK. last_served flag (A/B). Reset: state=IDLE, last_served=B (A wins the first tie), a_ack=b_ack=0, a_rdata=b_rdata=0.
- IDLE: only a_req -> GNT_A; only b_req -> GNT_B; both -> grant the port not equal to last_served; none -> stay.
- GNT_x (exactly 1 cycle): mem_addr=x_addr, mem_wdata=x_wdata, mem_wr=x_we. At the clock edge ending the cycle: x_rdata<=mem_rdata if !x_we (holds previous value on writes), x_ack<=1, last_served<=x, state<=ACK.
- ACK (exactly 1 cycle): x_ack=1 for the port just served. Arbitrate with that port's req masked (the requester is still holding it this cycle): other port requesting -> GNT_other; else -> IDLE. x_ack clears at the end of ACK.
- Latency: req seen in IDLE at cycle 0 -> memory access in cycle 1 -> ack in cycle 2. Back-to-back alternating A/B: one access every 2 cycles. Same port repeated: 3 cycles per access (ACK -> IDLE -> GNT).
- Outside GNT states: mem_wr=0, and mem_addr/mem_wdata show port A's inputs (don't-care values, but mem_wr must stay 0).
- mem_wr is decoded from the state register only, never directly from a request, so at most one write strobe is issued per grant.
- Never more than one of a_ack/b_ack high in a cycle; an ack never occurs without a preceding GNT cycle.
- Protocol violation (req dropped before ack): the granted access still completes and is acked. No recovery is attempted.
- Reset mid-operation: state returns to IDLE at once, acks clear, mem_wr=0 immediately (combinational from state). An access interrupted in GNT is lost and not acked. After rst deasserts, arbitration restarts with A priority.
- Addresses are used unmodified: no wrap or bounds logic, and the full 2^AW range is accessible.

Test Plan:
- Reset: hold rst with a_req=b_req=1 -> mem_wr=0, acks 0, busy 0. Release -> GNT_A first: mem_addr=a_addr in cycle 1, a_ack in cycle 2.
- A write then read: a_we=1, a_addr=16'h0010, a_wdata=32'hDEADBEEF -> one mem_wr pulse, a_ack at cycle 2. Then a read of 16'h0010 -> a_rdata=32'hDEADBEEF with a_ack.
- Contention: a_req and b_req both held continuously -> grants alternate A,B,A,B every 2 cycles. No two consecutive acks to the same port, and b_ack is never high together with a_ack.
- B-only stream: b_req re-asserted right after each ack -> 3-cycle cadence (GNT_B, ACK, IDLE), with busy low exactly in the IDLE cycles.
- Read-after-write across ports: B writes 32'h12345678 to 16'hFFFF while A's read of 16'hFFFF is pending behind it -> a_rdata=32'h12345678.
- Async reset asserted during GNT_B with b_we=1 -> mem_wr drops in the same cycle, no b_ack, state IDLE after release.
